mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of addressable memory words.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 4, meaning the address width in bits.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the command FIFO entry count.
REQ-005 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles to wait for ready.
REQ-006 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port cmd_valid, input, 1 bit: a command is offered.
REQ-009 Port cmd_ready, output, 1 bit: the block accepts a command; equals !fifo_full.
REQ-010 Port cmd_wt_rd, input, 1 bit: command type, 1 = write, 0 = read.
REQ-011 Port cmd_addr, input, ADDR_WIDTH bits: command address.
REQ-012 Port cmd_wdata, input, WIDTH bits: command write data.
REQ-013 Port valid, output, 1 bit: memory request valid.
REQ-014 Port ready, input, 1 bit: memory request complete.
REQ-015 Ports wt_rd (1 bit), addr (ADDR_WIDTH bits) and wdata (WIDTH bits), outputs: memory request fields.
REQ-016 Port rdata, input, WIDTH bits: memory read data, valid in the read handshake cycle.
REQ-017 Port rsp_valid, output, 1 bit: a one-cycle response pulse; there is no backpressure.
REQ-018 Ports rsp_wt_rd (1 bit), rsp_data (WIDTH bits) and rsp_err (1 bit), outputs: response type, read data and error flag.
REQ-019 Port busy, output, 1 bit: asserted when the FSM is not IDLE or the FIFO is not empty.

Function
REQ-020 A command SHALL be pushed into the FIFO at the clock edge where cmd_valid && cmd_ready; cmd_ready SHALL depend on fullness only, not on a same-cycle pop.
REQ-021 The FSM SHALL have exactly the states IDLE, REQ and RSP.
REQ-022 In IDLE with the FIFO non-empty, the FSM SHALL pop one entry, register its fields onto wt_rd/addr/wdata, and go to REQ.
REQ-023 If a popped entry has addr >= DEPTH, the FSM SHALL go to RSP with rsp_err=1 and rsp_data=0, and valid SHALL never assert for that entry.
REQ-024 For a command pushed into an empty FIFO while in IDLE, valid SHALL first be high 2 cycles after the push edge.
REQ-025 In REQ, valid SHALL be 1 and wt_rd/addr/wdata SHALL be held stable until the handshake valid && ready.
REQ-026 On a read handshake, rdata SHALL be captured into rsp_data; on a write handshake, rsp_data SHALL be 0.
REQ-027 A timeout counter SHALL clear on entry to REQ and increment each cycle in REQ without ready.
REQ-028 When the timeout counter reaches TIMEOUT-1 without ready, the FSM SHALL drop valid the next cycle, go to RSP with rsp_err=1 and rsp_data=0, and ignore any later ready.
REQ-029 On a handshake, the FSM SHALL go to RSP with rsp_err=0.
REQ-030 In RSP, rsp_valid SHALL be 1 for exactly one cycle, rsp_wt_rd SHALL equal the request type, and the FSM SHALL return to IDLE.
REQ-031 The minimum issue interval SHALL be 3 cycles per command, with one request outstanding at most.
REQ-032 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be $clog2(FIFO_DEPTH+1) bits wide and the timeout counter $clog2(TIMEOUT+1) bits wide.
REQ-033 A push while full SHALL be impossible by construction; a pop SHALL occur only when count > 0 at the start of the cycle.
REQ-034 Commands SHALL issue strictly in FIFO order.

Reset
REQ-035 While rst=0, the outputs SHALL be: valid=0, wt_rd=0, addr=0, wdata=0, rsp_valid=0, rsp_wt_rd=0, rsp_data=0, rsp_err=0, busy=0 and cmd_ready=1.
REQ-036 Reset asserted mid-request SHALL drop valid immediately (asynchronously), flush the FIFO, clear all counters and force IDLE, and no response SHALL be issued for the aborted command.
REQ-037 After rst deasserts, the first push SHALL be accepted on the next rising edge.

Structure
REQ-038 Package mem_master_pkg SHALL hold the state enum typedef (IDLE/REQ/RSP) and the packed cmd struct {wt_rd, addr, wdata}; widths come from the module parameters via a parameterized struct or by passing width constants.
REQ-039 Sub-module mem_cmd_fifo SHALL be a synchronous FIFO of cmd entries, parameterized by FIFO_DEPTH, providing full, empty and count.
REQ-040 The mem_master top SHALL contain the FSM, the timeout counter, the request registers and the response registers.

Verification
REQ-041 Write addr=3, wdata=8'hA5; memory ready after 2 cycles -> valid high 2 cycles post-push, rsp_valid pulse with rsp_wt_rd=1, rsp_err=0, rsp_data=0.
REQ-042 Read addr=3 after that write -> rsp_data=8'hA5, rsp_err=0, with the request fields stable throughout REQ.
REQ-043 Push 5 commands back-to-back with memory stalled -> cmd_ready=0 after 4 (or 5 if one is popped), responses arrive in push order, and no command is lost.
REQ-044 Memory never asserts ready, TIMEOUT=16 -> valid high for exactly 16 cycles, then rsp_err=1, rsp_data=0, and the next command proceeds normally.
REQ-045 Instance with DEPTH=10, read addr=12 -> valid never asserts, rsp_err=1.
REQ-046 Assert rst during REQ of a read -> valid=0 immediately, no rsp_valid, cmd_ready=1, busy=0, and a fresh write completes normally.

Source files
------------

// File: rtl/mem_master_pkg.sv
// Shared types for the mem_master command/request sequencer.
package mem_master_pkg;

  // Field widths of a queued command; the mem_master width parameters
  // default to these so the FIFO entry and the ports line up.
  localparam int CMD_WIDTH      = 8;
  localparam int CMD_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef struct packed {
    logic                      wt_rd;
    logic [CMD_ADDR_WIDTH-1:0] addr;
    logic [CMD_WIDTH-1:0]      wdata;
  } cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO of queued memory commands.
module mem_cmd_fifo
  import mem_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  cmd_t          wr_data,
  input  logic          pop,
  output cmd_t          rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  cmd_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Pointers wrap at FIFO_DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; stale entries are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mem_master.sv
// Queues read/write commands and issues them one at a time to a memory
// with a valid/ready handshake, a response timeout and an address check.
//
//   state | meaning
//   IDLE  | no request in flight; pops the next queued command
//   REQ   | valid high, waiting for ready or the timeout
//   RSP   | one-cycle response pulse, then back to IDLE
module mem_master
  import mem_master_pkg::*;
#(
  parameter int WIDTH      = CMD_WIDTH,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = CMD_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wt_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  output logic                  valid,
  input  logic                  ready,
  output logic                  wt_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  rsp_valid,
  output logic                  rsp_wt_rd,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  cmd_t          push_cmd;
  cmd_t          head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          pop;
  logic          addr_bad;
  logic [TW-1:0] tcnt;

  assign push_cmd  = {cmd_wt_rd, cmd_addr, cmd_wdata};
  assign cmd_ready = !full;
  assign valid     = (state == REQ);
  assign rsp_valid = (state == RSP);
  assign busy      = (state != IDLE) || (count != '0);

  mem_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_valid),
    .wr_data (push_cmd),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // An address can only be out of range when DEPTH leaves part of the
  // address space unpopulated.
  if (DEPTH >= (1 << ADDR_WIDTH)) begin : g_addr_all_ok
    assign addr_bad = 1'b0;
  end else begin : g_addr_check
    assign addr_bad = (head.addr >= ADDR_WIDTH'(DEPTH));
  end

  // State register; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and FIFO pop.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = addr_bad ? RSP : REQ;
        end
      end
      REQ: begin
        if (ready || (tcnt == TLAST)) state_nxt = RSP;
      end
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields, timeout counter and response fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wt_rd     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      tcnt      <= '0;
      rsp_wt_rd <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            wt_rd     <= head.wt_rd;
            addr      <= head.addr;
            wdata     <= head.wdata;
            tcnt      <= '0;
            rsp_wt_rd <= head.wt_rd;
            rsp_err   <= addr_bad;
            rsp_data  <= '0;
          end
        end
        REQ: begin
          if (ready) begin
            rsp_err  <= 1'b0;
            rsp_data <= wt_rd ? '0 : rdata;
          end else if (tcnt == TLAST) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Randomized and directed bench for mem_master against a queue-based model.
module tb_mem_master;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_wt_rd;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       valid, ready, wt_rd;
  logic [3:0] addr;
  logic [7:0] wdata, rdata;
  logic       rsp_valid, rsp_wt_rd, rsp_err, busy;
  logic [7:0] rsp_data;

  logic       cmd_valid_b, cmd_ready_b, valid_b, ready_b, wt_rd_b;
  logic [3:0] addr_b;
  logic [7:0] wdata_b, rsp_data_b;
  logic       rsp_valid_b, rsp_wt_rd_b, rsp_err_b, busy_b;

  always #5 clk = ~clk;

  mem_master #(.WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4), .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wt_rd(cmd_wt_rd), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .valid(valid), .ready(ready), .wt_rd(wt_rd), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rsp_valid(rsp_valid), .rsp_wt_rd(rsp_wt_rd),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy));

  mem_master #(.WIDTH(8), .DEPTH(10), .ADDR_WIDTH(4), .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut_d10 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_wt_rd(cmd_wt_rd), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .valid(valid_b), .ready(ready_b), .wt_rd(wt_rd_b), .addr(addr_b), .wdata(wdata_b),
    .rdata(rdata), .rsp_valid(rsp_valid_b), .rsp_wt_rd(rsp_wt_rd_b),
    .rsp_data(rsp_data_b), .rsp_err(rsp_err_b), .busy(busy_b));

  typedef struct { bit wt_rd; bit [3:0] addr; bit [7:0] wdata; int lat; } req_t;
  typedef struct { bit wt_rd; bit err; bit [7:0] data; } rsp_t;

  req_t     issue_q[$];
  rsp_t     exp_rsp[$];
  bit [7:0] ref_mem [16];
  bit [7:0] dev_mem [16];
  int       n_checks = 0, n_errors = 0, n_timeouts = 0, exp_timeouts = 0;
  int       next_lat = 0;
  int       vcnt = 0;
  bit       in_req = 1'b0, prev_rsp = 1'b0;
  req_t     cur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outcome of an accepted command, decided when it is queued:
  // commands complete in push order, so the model memory is updated here.
  task automatic model_push();
    req_t r;
    rsp_t e;
    r.wt_rd = cmd_wt_rd; r.addr = cmd_addr; r.wdata = cmd_wdata; r.lat = next_lat;
    issue_q.push_back(r);
    e.wt_rd = cmd_wt_rd;
    if (next_lat >= TIMEOUT) begin
      e.err = 1'b1; e.data = 8'h00; exp_timeouts++;
    end else begin
      e.err = 1'b0;
      if (cmd_wt_rd) begin ref_mem[cmd_addr] = cmd_wdata; e.data = 8'h00; end
      else e.data = ref_mem[cmd_addr];
    end
    exp_rsp.push_back(e);
  endtask

  // Memory responder and response checker, run once per cycle.
  task automatic monitor();
    rsp_t e;
    if (rsp_valid) begin
      check_eq("rsp_one_cycle", prev_rsp, 0);
      if (exp_rsp.size() == 0) check_eq("rsp_unexpected", rsp_valid, 0);
      else begin
        e = exp_rsp.pop_front();
        check_eq("rsp_wt_rd", rsp_wt_rd, e.wt_rd);
        check_eq("rsp_err", rsp_err, e.err);
        check_eq("rsp_data", rsp_data, e.data);
      end
    end
    prev_rsp = rsp_valid;
    ready = 1'b0;
    rdata = 8'($urandom);
    if (valid) begin
      if (!in_req) begin
        if (issue_q.size() == 0) check_eq("valid_unexpected", valid, 0);
        else begin cur = issue_q.pop_front(); in_req = 1'b1; vcnt = 0; end
      end
      if (in_req) begin
        check_eq("req_wt_rd", wt_rd, cur.wt_rd);
        check_eq("req_addr", addr, cur.addr);
        check_eq("req_wdata", wdata, cur.wdata);
        if (vcnt == cur.lat) begin
          ready = 1'b1;
          if (cur.wt_rd) dev_mem[cur.addr] = cur.wdata;
          else rdata = dev_mem[cur.addr];
          in_req = 1'b0;
        end
        vcnt++;
      end
    end else begin
      if (in_req) begin
        check_eq("timeout_len", vcnt, TIMEOUT);
        n_timeouts++;
        in_req = 1'b0;
      end
      ready = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic tick();
    if (cmd_valid && cmd_ready) model_push();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic push_cmd(input bit w, input logic [3:0] a, input logic [7:0] d, input int l);
    cmd_valid = 1'b1; cmd_wt_rd = w; cmd_addr = a; cmd_wdata = d; next_lat = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_rsp.size() != 0 || busy); i++) tick();
    check_eq("drain_rsp_pending", exp_rsp.size(), 0);
    check_eq("drain_issue_pending", issue_q.size(), 0);
    check_eq("drain_busy", busy, 0);
  endtask

  function automatic int pick_lat();
    case ($urandom_range(0, 9))
      0:       return TIMEOUT - 1;
      1:       return TIMEOUT + 3;
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic d10_read(input logic [3:0] a, input bit exp_bad);
    int       seen_v = 0;
    int       seen_r = 0;
    logic     e = 1'b0;
    logic [7:0] d = 8'h00;
    cmd_addr = a; cmd_wt_rd = 1'b0; cmd_valid_b = 1'b1;
    tick();
    cmd_valid_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_b) seen_v++;
      if (rsp_valid_b) begin seen_r++; e = rsp_err_b; d = rsp_data_b; end
    end
    check_eq("d10_valid_seen", seen_v != 0, !exp_bad);
    check_eq("d10_rsp_count", seen_r, 1);
    check_eq("d10_rsp_err", e, exp_bad);
    if (exp_bad) check_eq("d10_rsp_data", d, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_valid_b = 1'b0; cmd_wt_rd = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; ready = 1'b0; ready_b = 1'b1; rdata = '0;
    tick(); tick();
    check_eq("rst_valid", valid, 0);
    check_eq("rst_wt_rd", wt_rd, 0);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_wdata", wdata, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_wt_rd", rsp_wt_rd, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b1;
    tick();

    // Write then read back, with issue latency checked on the write.
    push_cmd(1'b1, 4'd3, 8'hA5, 2);
    check_eq("valid_before_issue", valid, 0);
    tick();
    check_eq("valid_issue_latency", valid, 1);
    drain(40);
    push_cmd(1'b0, 4'd3, 8'h00, 3);
    drain(40);

    // Back-to-back pushes against a stalled memory fill the queue.
    for (int i = 0; i < 6; i++) begin
      check_eq("cmd_ready_b2b", cmd_ready, (i < 5) ? 1 : 0);
      cmd_valid = 1'b1; cmd_wt_rd = 1'($urandom_range(0, 1));
      cmd_addr = 4'($urandom_range(0, 15)); cmd_wdata = 8'($urandom);
      next_lat = (i == 0) ? 6 : int'($urandom_range(0, 2));
      tick();
    end
    cmd_valid = 1'b0;
    drain(80);

    // Timeout, the next command after it, and ready on the last allowed cycle.
    push_cmd(1'b0, 4'd3, 8'h00, TIMEOUT + 5);
    push_cmd(1'b1, 4'd9, 8'h5A, 0);
    push_cmd(1'b0, 4'd9, 8'h00, 1);
    drain(80);
    push_cmd(1'b1, 4'd2, 8'h77, TIMEOUT - 1);
    push_cmd(1'b0, 4'd2, 8'h00, 0);
    drain(80);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1)); cmd_wt_rd = 1'($urandom_range(0, 1));
      cmd_addr = 4'($urandom_range(0, 15)); cmd_wdata = 8'($urandom);
      next_lat = pick_lat();
      tick();
    end
    cmd_valid = 1'b0;
    drain(1500);

    // Out-of-range and in-range reads on the DEPTH=10 instance.
    d10_read(4'd12, 1'b1);
    d10_read(4'd9, 1'b0);

    // Reset in the middle of a read request.
    push_cmd(1'b0, 4'd5, 8'h00, 10);
    tick();
    check_eq("abort_valid_up", valid, 1);
    tick(); tick();
    #3 rst = 1'b0;
    #1;
    check_eq("abort_valid", valid, 0);
    check_eq("abort_cmd_ready", cmd_ready, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_rsp_valid", rsp_valid, 0);
    in_req = 1'b0;
    issue_q.delete();
    exp_rsp.delete();
    tick(); tick();
    rst = 1'b1;
    push_cmd(1'b1, 4'd7, 8'h3C, 1);
    check_eq("first_push_after_reset", busy, 1);
    push_cmd(1'b0, 4'd7, 8'h00, 0);
    drain(40);

    check_eq("timeout_count", n_timeouts, exp_timeouts);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
